// File: rtl/reflet_bus_arbiter_pkg.sv
// Shared types for the two-master system bus arbiter.
package reflet_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/reflet_arbiter_hold_counter.sv
// Saturating grant-tenure counter; at_limit flags that the current owner
// has used up its contested hold time.
module reflet_arbiter_hold_counter #(
    parameter int max_hold = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam int CW    = (max_hold < 2) ? 1 : $clog2(max_hold + 1);
    localparam int LIMIT = (max_hold == 0) ? 0 : max_hold - 1;
    localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT_V)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // max_hold = 0 disables preemption entirely
    assign at_limit = (max_hold != 0) && (cnt_q == LIMIT_V);

endmodule

// File: rtl/reflet_bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded hold time and owner lock.
// Grants and the bus mux follow the registered state, so owner switches need no idle cycle.
module reflet_bus_arbiter
    import reflet_bus_arbiter_pkg::*;
#(
    parameter int wordsize = 8,
    parameter int max_hold = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic                m0_lock,
    input  logic [wordsize-1:0] m0_addr,
    input  logic [wordsize-1:0] m0_data_out,
    input  logic                m0_write_en,
    output logic                m0_grant,
    output logic [wordsize-1:0] m0_data_in,
    input  logic                m1_req,
    input  logic                m1_lock,
    input  logic [wordsize-1:0] m1_addr,
    input  logic [wordsize-1:0] m1_data_out,
    input  logic                m1_write_en,
    output logic                m1_grant,
    output logic [wordsize-1:0] m1_data_in,
    output logic [wordsize-1:0] bus_addr,
    output logic [wordsize-1:0] bus_data_out,
    output logic                bus_write_en,
    input  logic [wordsize-1:0] bus_data_in,
    output logic                cpu_en
);

    arb_state_e state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic       hold_clr, hold_inc, hold_limit;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_d = last_owner_q ? OWN0 : OWN1;
                end else if (m0_req) begin
                    state_d = OWN0;
                end else if (m1_req) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!m0_req) begin
                    state_d = m1_req ? OWN1 : IDLE;
                end else if (m1_req && !m0_lock && hold_limit) begin
                    state_d = OWN1;
                end
            end
            OWN1: begin
                if (!m1_req) begin
                    state_d = m0_req ? OWN0 : IDLE;
                end else if (m0_req && !m1_lock && hold_limit) begin
                    state_d = OWN0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == OWN0 && state_q != OWN0) last_owner_d = 1'b0;
        if (state_d == OWN1 && state_q != OWN1) last_owner_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Tenure only accrues while contested, so a lone owner is never preempted
    assign hold_clr = (state_d != state_q);
    assign hold_inc = ((state_q == OWN0) && m1_req) || ((state_q == OWN1) && m0_req);

    reflet_arbiter_hold_counter #(
        .max_hold (max_hold)
    ) u_hold_counter (
        .clk      (clk),
        .reset    (reset),
        .clr      (hold_clr),
        .inc      (hold_inc),
        .at_limit (hold_limit)
    );

    assign m0_grant = (state_q == OWN0);
    assign m1_grant = (state_q == OWN1);

    always_comb begin
        bus_addr     = '0;
        bus_data_out = '0;
        bus_write_en = 1'b0;
        case (state_q)
            OWN0: begin
                bus_addr     = m0_addr;
                bus_data_out = m0_data_out;
                bus_write_en = m0_write_en;
            end
            OWN1: begin
                bus_addr     = m1_addr;
                bus_data_out = m1_data_out;
                bus_write_en = m1_write_en;
            end
            default: ;
        endcase
    end

    assign m0_data_in = m0_grant ? bus_data_in : '0;
    assign m1_data_in = m1_grant ? bus_data_in : '0;
    assign cpu_en     = m0_grant | ~m0_req;

endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// Directed plus randomized check of the bus arbiter against a cycle-level
// ownership model kept in plain integers.
module tb_reflet_bus_arbiter;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       m0_req, m0_lock, m0_write_en;
    logic [7:0] m0_addr, m0_data_out;
    logic       m1_req, m1_lock, m1_write_en;
    logic [7:0] m1_addr, m1_data_out;
    logic       m0_grant, m1_grant;
    logic [7:0] m0_data_in, m1_data_in;
    logic [7:0] bus_addr, bus_data_out, bus_data_in;
    logic       bus_write_en, cpu_en;

    int n_checks = 0;
    int n_fail   = 0;

    int mdl_owner;
    int mdl_last;
    int mdl_hold;

    logic wr90_seen;
    logic [1:0] hist;

    always #5 clk = ~clk;

    reflet_bus_arbiter #(.wordsize(8), .max_hold(MAXH)) dut (
        .clk          (clk),
        .reset        (reset),
        .m0_req       (m0_req),
        .m0_lock      (m0_lock),
        .m0_addr      (m0_addr),
        .m0_data_out  (m0_data_out),
        .m0_write_en  (m0_write_en),
        .m0_grant     (m0_grant),
        .m0_data_in   (m0_data_in),
        .m1_req       (m1_req),
        .m1_lock      (m1_lock),
        .m1_addr      (m1_addr),
        .m1_data_out  (m1_data_out),
        .m1_write_en  (m1_write_en),
        .m1_grant     (m1_grant),
        .m1_data_in   (m1_data_in),
        .bus_addr     (bus_addr),
        .bus_data_out (bus_data_out),
        .bus_write_en (bus_write_en),
        .bus_data_in  (bus_data_in),
        .cpu_en       (cpu_en)
    );

    always @(posedge clk or negedge reset) begin
        if (!reset) wr90_seen <= 1'b0;
        else if (bus_write_en && bus_addr == 8'h90) wr90_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_lock = 0; m0_write_en = 0; m0_addr = 0; m0_data_out = 0;
        m1_req = 0; m1_lock = 0; m1_write_en = 0; m1_addr = 0; m1_data_out = 0;
        bus_data_in = 0;
    endtask

    task automatic model_reset();
        mdl_owner = -1;
        mdl_last  = 1;
        mdl_hold  = 0;
    endtask

    // Ownership rules applied at a clock edge with the inputs present at that edge
    task automatic model_edge();
        int req[2];
        int lck[2];
        int nxt, me, other;
        req[0] = int'(m0_req); req[1] = int'(m1_req);
        lck[0] = int'(m0_lock); lck[1] = int'(m1_lock);
        if (mdl_owner < 0) begin
            if (req[0] != 0 && req[1] != 0) nxt = (mdl_last == 1) ? 0 : 1;
            else if (req[0] != 0) nxt = 0;
            else if (req[1] != 0) nxt = 1;
            else nxt = -1;
        end else begin
            me = mdl_owner;
            other = 1 - me;
            if (req[me] == 0) nxt = (req[other] != 0) ? other : -1;
            else if (req[other] != 0 && lck[me] == 0 && MAXH != 0 && mdl_hold >= MAXH - 1) nxt = other;
            else nxt = me;
        end
        if (nxt != mdl_owner) begin
            mdl_hold = 0;
        end else if (mdl_owner >= 0 && req[1 - mdl_owner] != 0 && MAXH > 0) begin
            mdl_hold = (mdl_hold + 1 > MAXH - 1) ? MAXH - 1 : mdl_hold + 1;
        end
        if (nxt != mdl_owner && nxt >= 0) mdl_last = nxt;
        mdl_owner = nxt;
    endtask

    task automatic check_model();
        logic [7:0] ea, ed;
        logic       ew;
        ea = 0; ed = 0; ew = 0;
        if (mdl_owner == 0) begin ea = m0_addr; ed = m0_data_out; ew = m0_write_en; end
        if (mdl_owner == 1) begin ea = m1_addr; ed = m1_data_out; ew = m1_write_en; end
        check("m0_grant", m0_grant, mdl_owner == 0);
        check("m1_grant", m1_grant, mdl_owner == 1);
        check("bus_addr", bus_addr, ea);
        check("bus_data_out", bus_data_out, ed);
        check("bus_write_en", bus_write_en, ew);
        check("m0_data_in", m0_data_in, (mdl_owner == 0) ? bus_data_in : 8'h00);
        check("m1_data_in", m1_data_in, (mdl_owner == 1) ? bus_data_in : 8'h00);
        check("cpu_en", cpu_en, (mdl_owner == 0) || !m0_req);
    endtask

    // Called just after a falling edge with inputs set; returns at the next falling edge
    task automatic step();
        #1;
        check_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        #1;
        model_reset();
        check("rst_m0_grant", m0_grant, 0);
        check("rst_m1_grant", m1_grant, 0);
        check("rst_bus_write_en", bus_write_en, 0);
        check("rst_bus_addr", bus_addr, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // 1: single request, one-cycle grant latency
        step();
        m0_req = 1; m0_addr = 8'h42;
        step();
        check("t1_m0_grant", m0_grant, 1);
        check("t1_bus_addr", bus_addr, 8'h42);
        check("t1_m1_grant", m1_grant, 0);

        // 2: simultaneous requests alternate every MAXH cycles, master 0 first
        do_reset();
        m0_req = 1; m1_req = 1;
        for (int i = 0; i < 16; i++) begin
            step();
            hist = {m1_grant, m0_grant};
            check("t2_rr_owner", hist, (((i / MAXH) % 2) == 0) ? 2'b01 : 2'b10);
        end

        // 3: lock holds off preemption, release hands over at next edge
        do_reset();
        m0_req = 1; m0_lock = 1;
        step();
        m1_req = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("t3_locked_m0_grant", m0_grant, 1);
        end
        m0_lock = 0;
        step();
        check("t3_release_m1_grant", m1_grant, 1);

        // 4: non-owner write strobe never reaches the bus
        do_reset();
        m1_req = 1; m1_lock = 1; m1_addr = 8'h10; m1_write_en = 0;
        step();
        m0_req = 1; m0_write_en = 1; m0_addr = 8'h90; m0_data_out = 8'hEE;
        step();
        step();
        check("t4_bus_write_en", bus_write_en, 0);
        check("t4_bus_addr", bus_addr, 8'h10);
        check("t4_cpu_stalled", cpu_en, 0);
        check("t4_no_write_90", wr90_seen, 0);

        // 5: read data routed only to the owner
        bus_data_in = 8'h5A;
        #1;
        check("t5_m1_data_in", m1_data_in, 8'h5A);
        check("t5_m0_data_in", m0_data_in, 8'h00);
        step();

        // 6: asynchronous reset mid-write
        do_reset();
        m0_req = 1; m0_write_en = 1; m0_addr = 8'h33; m0_data_out = 8'hC3;
        step();
        check("t6_pre_write_en", bus_write_en, 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_m0_grant", m0_grant, 0);
        check("t6_async_write_en", bus_write_en, 0);
        model_reset();
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        step();
        check("t6_idle_m0_grant", m0_grant, 0);
        check("t6_idle_m1_grant", m1_grant, 0);
        check("t6_idle_bus_addr", bus_addr, 0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            m0_req      = ($urandom_range(0, 3) != 0);
            m1_req      = ($urandom_range(0, 3) != 0);
            m0_lock     = ($urandom_range(0, 7) == 0);
            m1_lock     = ($urandom_range(0, 7) == 0);
            m0_write_en = $urandom_range(0, 1) != 0;
            m1_write_en = $urandom_range(0, 1) != 0;
            m0_addr     = 8'($urandom);
            m1_addr     = 8'($urandom);
            m0_data_out = 8'($urandom);
            m1_data_out = 8'($urandom);
            bus_data_in = 8'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
